// File: rtl/axa_mul_arbiter_pkg.sv
// Shared definitions for the AxA multiplier arbiter: FSM encoding,
// operand/result widths and the IEEE-754 field offsets inside the packed buses.
package axa_mul_arbiter_pkg;

  // Bus widths: eight single-precision operands in, four results out.
  localparam int FP_W = 32;
  localparam int AB_W = 8 * FP_W;
  localparam int C_W  = 4 * FP_W;

  // Operand bus {A11,A12,A21,A22,B11,B12,B21,B22}, A11 in the top word.
  localparam int A11_LSB = 224;
  localparam int A12_LSB = 192;
  localparam int A21_LSB = 160;
  localparam int A22_LSB = 128;
  localparam int B11_LSB = 96;
  localparam int B12_LSB = 64;
  localparam int B21_LSB = 32;
  localparam int B22_LSB = 0;

  // Result bus {C11,C12,C21,C22}, C11 in the top word.
  localparam int C11_LSB = 96;
  localparam int C12_LSB = 64;
  localparam int C21_LSB = 32;
  localparam int C22_LSB = 0;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  // Result bus seen by a requester: forced to zero unless it is the one being served.
  function automatic logic [C_W-1:0] gate_c(input logic en, input logic [C_W-1:0] c);
    return en ? c : '0;
  endfunction

endpackage

// File: rtl/axa_mul_arbiter_rr_picker.sv
// Combinational two-way round-robin picker. With both requesters asking, the one
// that was not served last wins; with a single requester, that requester wins.
module axa_mul_arbiter_rr_picker (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Pick the winner from the request pair and the last-served index.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~rr_last_i;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/axa_mul_arbiter.sv
// Shares a single 2x2 single-precision matrix multiplier between two requesters.
// Operands are latched on grant so the requester is released after AB_Ack; the
// multiplier Stable/C_Ack handshake is sequenced here, a watchdog aborts a stuck
// job, and the result (or an error) is handed back to the requester that won.
module axa_mul_arbiter
  import axa_mul_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,  // 0 disables the watchdog
  parameter int CNT_W          = 11     // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic         input_Clk,
  input  logic         input_Reset,

  input  logic         input_R0_Stable,
  input  logic [255:0] input_R0_AB,
  input  logic         input_R0_C_Ack,
  output logic         output_R0_AB_Ack,
  output logic         output_R0_Stable,
  output logic         output_R0_Err,
  output logic [127:0] output_R0_C,

  input  logic         input_R1_Stable,
  input  logic [255:0] input_R1_AB,
  input  logic         input_R1_C_Ack,
  output logic         output_R1_AB_Ack,
  output logic         output_R1_Stable,
  output logic         output_R1_Err,
  output logic [127:0] output_R1_C,

  output logic         output_Mul_Stable,
  output logic         output_Mul_C_Ack,
  output logic [255:0] output_Mul_AB,
  input  logic         input_Mul_Stable,
  input  logic [127:0] input_Mul_C,

  output logic         output_Busy
);

  // Last watchdog value before an abort; ISSUE lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              grant_q;    // requester currently owning the multiplier
  logic              rr_last_q;  // requester served most recently
  logic [AB_W-1:0]   ab_q;
  logic [C_W-1:0]    c_q;
  logic              err_q;
  logic [CNT_W-1:0]  wd_q;
  logic [1:0]        ab_ack_q;
  logic              c_ack_q;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              grant_go;
  logic              mul_done;
  logic              wd_expire;
  logic              c_ack_sel;
  logic              deliver_done;
  logic              dlv0;
  logic              dlv1;

  axa_mul_arbiter_rr_picker u_picker (
    .req_i       ({input_R1_Stable, input_R0_Stable}),
    .rr_last_i   (rr_last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // A grant needs a requester and a drained multiplier (its Stable low again).
  assign grant_go     = (state_q == ST_IDLE) && gnt_valid && !input_Mul_Stable;
  assign mul_done     = (state_q == ST_ISSUE) && input_Mul_Stable;
  // A result arriving on the last watchdog cycle wins over the abort.
  assign wd_expire    = (TIMEOUT_CYCLES != 0) && (state_q == ST_ISSUE) &&
                        !input_Mul_Stable && (wd_q == WD_LAST);
  // Only the granted requester's C_Ack can close a delivery.
  assign c_ack_sel    = grant_q ? input_R1_C_Ack : input_R0_C_Ack;
  assign deliver_done = (state_q == ST_DELIVER) && c_ack_sel;

  // State register.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!input_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_go)               state_d = ST_ISSUE;
      ST_ISSUE:   if (mul_done || wd_expire)  state_d = ST_DELIVER;
      ST_DELIVER: if (deliver_done)           state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Grant bookkeeping and operand capture on the grant edge.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    // NOTE: the wide operand/result registers are reset too, because they drive ports that must read zero after reset.
    if (!input_Reset) begin
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      ab_q      <= '0;
    end else begin
      if (grant_go) begin
        grant_q <= gnt_idx;
        ab_q    <= gnt_idx ? input_R1_AB : input_R0_AB;
      end
      if (deliver_done) begin
        rr_last_q <= grant_q;
      end
    end
  end

  // Watchdog: counts ISSUE cycles without a multiplier result.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      wd_q <= '0;
    end else if (grant_go) begin
      wd_q <= '0;
    end else if ((state_q == ST_ISSUE) && !input_Mul_Stable && !wd_expire) begin
      wd_q <= wd_q + CNT_W'(1);
    end
  end

  // Result and error registers: loaded on completion or abort, error cleared on consume.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      c_q   <= '0;
      err_q <= 1'b0;
    end else if (mul_done) begin
      c_q   <= input_Mul_C;
      err_q <= 1'b0;
    end else if (wd_expire) begin
      c_q   <= '0;
      err_q <= 1'b1;
    end else if (deliver_done) begin
      err_q <= 1'b0;
    end
  end

  // Single-cycle handshake pulses: AB_Ack after grant, Mul_C_Ack after result or abort.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      ab_ack_q <= 2'b00;
      c_ack_q  <= 1'b0;
    end else begin
      ab_ack_q <= grant_go ? {gnt_idx, ~gnt_idx} : 2'b00;
      c_ack_q  <= mul_done | wd_expire;
    end
  end

  // Output decode: every port is a function of registered state only.
  always_comb begin
    dlv0              = (state_q == ST_DELIVER) && !grant_q;
    dlv1              = (state_q == ST_DELIVER) &&  grant_q;

    output_R0_AB_Ack  = ab_ack_q[0];
    output_R0_Stable  = dlv0;
    output_R0_Err     = dlv0 & err_q;
    output_R0_C       = gate_c(dlv0, c_q);

    output_R1_AB_Ack  = ab_ack_q[1];
    output_R1_Stable  = dlv1;
    output_R1_Err     = dlv1 & err_q;
    output_R1_C       = gate_c(dlv1, c_q);

    output_Mul_Stable = (state_q == ST_ISSUE);
    output_Mul_C_Ack  = c_ack_q;
    output_Mul_AB     = ab_q;
    output_Busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_axa_mul_arbiter.sv
// Self-checking bench for axa_mul_arbiter: a behavioural multiplier with
// programmable latency/hold, two requester drivers and a delivery scoreboard.
module tb_axa_mul_arbiter;
  import axa_mul_arbiter_pkg::*;

  localparam int TO = 16;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       r_stable = 2'b00;
  logic [AB_W-1:0]  r_ab [2];
  logic [1:0]       r_c_ack;
  logic [1:0]       o_ab_ack, o_stable, o_err;
  logic [C_W-1:0]   o_c [2];
  logic             o_mul_stable, o_mul_c_ack, o_busy;
  logic [AB_W-1:0]  o_mul_ab;
  logic             m_stable;
  logic [C_W-1:0]   m_c;

  typedef struct {
    logic [C_W-1:0] c;
    logic           err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   served[$];
  int   dlv_cyc [2];
  int   ack_cyc [2];
  int   ack_lat [2];
  int   ack_delay [2];
  int   cyc = 0;
  int   mdl_lat = 5;
  int   mdl_hold = 0;
  bit   mdl_never = 1'b0;
  int   stray_req = 0;
  int   n_err = 0;
  int   n_checks = 0;

  axa_mul_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .input_Clk         (clk),
    .input_Reset       (rst_n),
    .input_R0_Stable   (r_stable[0]),
    .input_R0_AB       (r_ab[0]),
    .input_R0_C_Ack    (r_c_ack[0]),
    .output_R0_AB_Ack  (o_ab_ack[0]),
    .output_R0_Stable  (o_stable[0]),
    .output_R0_Err     (o_err[0]),
    .output_R0_C       (o_c[0]),
    .input_R1_Stable   (r_stable[1]),
    .input_R1_AB       (r_ab[1]),
    .input_R1_C_Ack    (r_c_ack[1]),
    .output_R1_AB_Ack  (o_ab_ack[1]),
    .output_R1_Stable  (o_stable[1]),
    .output_R1_Err     (o_err[1]),
    .output_R1_C       (o_c[1]),
    .output_Mul_Stable (o_mul_stable),
    .output_Mul_C_Ack  (o_mul_c_ack),
    .output_Mul_AB     (o_mul_ab),
    .input_Mul_Stable  (m_stable),
    .input_Mul_C       (m_c),
    .output_Busy       (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---- single-precision helpers (normal numbers, exact small-integer math) ----
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [C_W-1:0] mat_mul(input logic [AB_W-1:0] ab);
    real a11, a12, a21, a22, b11, b12, b21, b22;
    a11 = f2r(ab[A11_LSB +: FP_W]); a12 = f2r(ab[A12_LSB +: FP_W]);
    a21 = f2r(ab[A21_LSB +: FP_W]); a22 = f2r(ab[A22_LSB +: FP_W]);
    b11 = f2r(ab[B11_LSB +: FP_W]); b12 = f2r(ab[B12_LSB +: FP_W]);
    b21 = f2r(ab[B21_LSB +: FP_W]); b22 = f2r(ab[B22_LSB +: FP_W]);
    return {r2f(a11 * b11 + a12 * b21), r2f(a11 * b12 + a12 * b22),
            r2f(a21 * b11 + a22 * b21), r2f(a21 * b12 + a22 * b22)};
  endfunction

  function automatic logic [AB_W-1:0] rand_ab();
    logic [AB_W-1:0] ab;
    for (int i = 0; i < 8; i++) ab[i*FP_W +: FP_W] = r2f(real'($urandom_range(9, 1)));
    return ab;
  endfunction

  // ---- behavioural multiplier: result after mdl_lat cycles, held mdl_hold cycles past C_Ack ----
  initial begin : model
    int mst, cnt, hcnt;
    mst = 0; cnt = 0; hcnt = 0;
    m_stable = 1'b0;
    m_c = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mst = 0;
        m_stable = 1'b0;
      end else begin
        case (mst)
          0: if (o_mul_stable && !mdl_never) begin cnt = 0; mst = 1; end
          1: if (!o_mul_stable) mst = 0;
             else begin
               cnt++;
               if (cnt >= mdl_lat) begin m_stable = 1'b1; m_c = mat_mul(o_mul_ab); mst = 2; end
             end
          2: if (o_mul_c_ack) begin hcnt = 0; mst = 3; end
          default: begin
            hcnt++;
            if (hcnt > mdl_hold) begin m_stable = 1'b0; mst = 0; end
          end
        endcase
      end
    end
  end

  // ---- delivery monitor: scoreboard pop/compare and requester C_Ack ----
  initial begin : monitor
    bit   seen [2];
    int   wcnt [2];
    int   stray_done;
    exp_t e;
    seen = '{1'b0, 1'b0};
    wcnt = '{0, 0};
    stray_done = 0;
    r_c_ack = 2'b00;
    forever begin
      @(posedge clk); #1;
      r_c_ack = 2'b00;
      if (!rst_n) begin
        seen = '{1'b0, 1'b0};
        wcnt = '{0, 0};
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (o_stable[n]) begin
            if (!seen[n]) begin
              seen[n] = 1'b1;
              dlv_cyc[n] = cyc;
              served.push_back(n);
              if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
                check($sformatf("r%0d_unexpected_delivery", n), 256'(1), 256'(0));
              end else begin
                if (n == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("r%0d_c", n), 256'(o_c[n]), 256'(e.c));
                check($sformatf("r%0d_err", n), 256'(o_err[n]), 256'(e.err));
              end
            end
            if (wcnt[n] >= ack_delay[n]) r_c_ack[n] = 1'b1;
            else wcnt[n]++;
          end else begin
            seen[n] = 1'b0;
            wcnt[n] = 0;
          end
        end
        if (stray_done != stray_req) begin
          r_c_ack[1] = 1'b1;
          stray_done = stray_req;
        end
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic raise(input int n, input logic [AB_W-1:0] ab, input logic [C_W-1:0] exp_c,
                       input logic err);
    exp_t e;
    e.c = exp_c;
    e.err = err;
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
    r_ab[n] = ab;
    r_stable[n] = 1'b1;
  endtask

  task automatic wait_acks(input logic [1:0] mask);
    logic [1:0] pend;
    int i;
    pend = mask;
    i = 0;
    while (pend != 2'b00 && i < 200) begin
      tick();
      i++;
      for (int n = 0; n < 2; n++) begin
        if (pend[n] && o_ab_ack[n]) begin
          r_stable[n] = 1'b0;
          pend[n] = 1'b0;
          ack_cyc[n] = cyc;
          ack_lat[n] = i;
        end
      end
    end
    check("ab_ack_timeout", 256'(pend), 256'(0));
    r_stable = r_stable & ~pend;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((o_busy || m_stable || q0.size() != 0 || q1.size() != 0) && i < 300) begin
      tick();
      i++;
    end
    check("idle_timeout", 256'(o_busy || m_stable || q0.size() != 0 || q1.size() != 0), 256'(0));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctl"}, 256'({o_ab_ack, o_stable, o_err, o_mul_stable, o_mul_c_ack, o_busy}), 256'(0));
    check({pfx, "_r0_c"}, 256'(o_c[0]), 256'(0));
    check({pfx, "_r1_c"}, 256'(o_c[1]), 256'(0));
    check({pfx, "_mul_ab"}, o_mul_ab, 256'(0));
  endtask

  // Both requesters raise Stable on the same edge; 'first' must win and the other
  // must be granted 2 + hold cycles after the winner's delivery.
  task automatic pair(input int first, input int hold);
    logic [AB_W-1:0] a0, a1;
    mdl_hold = hold;
    served.delete();
    a0 = rand_ab();
    a1 = rand_ab();
    raise(0, a0, mat_mul(a0), 1'b0);
    raise(1, a1, mat_mul(a1), 1'b0);
    wait_acks(2'b11);
    wait_idle();
    check("order_first", 256'((served.size() >= 1) ? served[0] : 9), 256'(first));
    check("order_second", 256'((served.size() >= 2) ? served[1] : 9), 256'(1 - first));
    check("winner_ack_lat", 256'(ack_lat[first]), 256'(1));
    check("regrant_gap", 256'(ack_cyc[1 - first] - dlv_cyc[first]), 256'(2 + hold));
    mdl_hold = 0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [AB_W-1:0] ab;
    int i;
    r_ab[0] = '0;
    r_ab[1] = '0;
    ack_delay = '{0, 0};

    // Reset: every output must read zero.
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous request straight out of reset: R0 first.
    pair(0, 0);

    // R0 alone, the reference 3/6/4/5 matrix, latency 5.
    ab = {32'h40400000, 32'h40C00000, 32'h40800000, 32'h40A00000,
          32'h40400000, 32'h40C00000, 32'h40800000, 32'h40A00000};
    mdl_lat = 5;
    raise(0, ab, {32'h42040000, 32'h42400000, 32'h42000000, 32'h42440000}, 1'b0);
    wait_acks(2'b01);
    check("t1_ack_lat", 256'(ack_lat[0]), 256'(1));
    check("t1_mul_stable", 256'(o_mul_stable), 256'(1));
    check("t1_mul_ab", o_mul_ab, ab);
    check("t1_busy", 256'(o_busy), 256'(1));
    wait_idle();

    // R0 was served last: a simultaneous pair now goes to R1 first.
    pair(1, 0);

    // Multiplier holds its Stable 3 cycles past C_Ack: pending grant slips 3 cycles.
    mdl_lat = 2;
    pair(1, 3);

    // Watchdog abort: model never answers.
    mdl_never = 1'b1;
    raise(0, rand_ab(), '0, 1'b1);
    wait_acks(2'b01);
    i = 0;
    while (!o_mul_c_ack && i < 40) begin
      tick();
      i++;
    end
    check("t3_abort_cycle", 256'(i), 256'(TO));
    check("t3_mul_stable_low", 256'(o_mul_stable), 256'(0));
    wait_idle();
    mdl_never = 1'b0;

    // Stray C_Ack from R1 while R0 is delivering is ignored.
    ack_delay[0] = 4;
    ab = rand_ab();
    raise(0, ab, mat_mul(ab), 1'b0);
    wait_acks(2'b01);
    i = 0;
    while (!o_stable[0] && i < 40) begin
      tick();
      i++;
    end
    check("t5_r0_delivers", 256'(o_stable[0]), 256'(1));
    stray_req++;
    tick();
    tick();
    check("t5_r0_still_stable", 256'(o_stable[0]), 256'(1));
    check("t5_r1_stable_low", 256'(o_stable[1]), 256'(0));
    i = 2;
    while (o_stable[0] && i < 40) begin
      tick();
      i++;
    end
    check("t5_stable_len", 256'(i), 256'(5));
    wait_idle();
    ack_delay[0] = 0;

    // Async reset in the middle of ISSUE: job dropped, then R0 priority restored.
    mdl_lat = 5;
    raise(0, rand_ab(), '0, 1'b0);
    wait_acks(2'b01);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q0.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pair(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
